// File: rtl/thread_scheduler.sv
// Round-robin picker over the thread state memory: finds the next thread in
// MATCH_STATE, offers it downstream, and writes NEXT_STATE back on acceptance.
module thread_scheduler #(
  parameter int N_THREADS        = 6,
  parameter int N_THREADS_MSB    = $clog2(N_THREADS) - 1,
  parameter int THREAD_STATE_MSB = 2,
  parameter logic [THREAD_STATE_MSB:0] MATCH_STATE = (THREAD_STATE_MSB+1)'(2),
  parameter logic [THREAD_STATE_MSB:0] NEXT_STATE  = (THREAD_STATE_MSB+1)'(3)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  output logic [N_THREADS_MSB:0]    rd_num,
  input  logic [THREAD_STATE_MSB:0] rd_state,
  output logic                      wr_en,
  output logic [N_THREADS_MSB:0]    wr_num,
  output logic [THREAD_STATE_MSB:0] wr_state,
  output logic                      out_valid,
  output logic [N_THREADS_MSB:0]    out_num,
  input  logic                      out_rdy,
  output logic                      err
);

  typedef enum logic [1:0] {SCAN, HOLD, WRITE} sched_e;

  localparam logic [N_THREADS_MSB:0] LAST = (N_THREADS_MSB+1)'(N_THREADS - 1);

  function automatic logic [N_THREADS_MSB:0] wrap_inc(input logic [N_THREADS_MSB:0] n);
    return (n == LAST) ? '0 : n + 1'b1;
  endfunction

  sched_e                   state_q, state_d;
  logic [N_THREADS_MSB:0]   ptr_q, ptr_d;
  logic                     out_valid_d, wr_en_d, err_d;
  logic [N_THREADS_MSB:0]   out_num_d, wr_num_d;
  logic [1:0]               guard_cnt_q, guard_cnt_d;
  logic [N_THREADS_MSB:0]   guard_num_q, guard_num_d;
  logic                     guarded;

  assign wr_state = NEXT_STATE;
  assign guarded  = (guard_cnt_q != 2'd0) && (guard_num_q == ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid;
    out_num_d   = out_num;
    wr_en_d     = 1'b0;
    wr_num_d    = wr_num;
    err_d       = err;
    guard_cnt_d = (guard_cnt_q != 2'd0) ? guard_cnt_q - 2'd1 : 2'd0;
    guard_num_d = guard_num_q;
    rd_num      = ptr_q;
    case (state_q)
      SCAN: begin
        if (en) begin
          if (rd_state == MATCH_STATE && !guarded) begin
            out_num_d   = ptr_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            ptr_d = wrap_inc(ptr_q);
          end
        end
      end
      HOLD: begin
        rd_num = out_num;
        // The held thread must stay eligible until it is consumed.
        if (rd_state != MATCH_STATE) err_d = 1'b1;
        if (out_valid && out_rdy) begin
          out_valid_d = 1'b0;
          wr_en_d     = 1'b1;
          wr_num_d    = out_num;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        rd_num = out_num;
        ptr_d  = wrap_inc(out_num);
        // Memory commit lags the strobe, so mask the thread until it lands.
        guard_cnt_d = 2'd3;
        guard_num_d = wr_num;
        state_d     = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SCAN;
      ptr_q       <= '0;
      out_valid   <= 1'b0;
      out_num     <= '0;
      wr_en       <= 1'b0;
      wr_num      <= '0;
      err         <= 1'b0;
      guard_cnt_q <= 2'd0;
      guard_num_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid   <= out_valid_d;
      out_num     <= out_num_d;
      wr_en       <= wr_en_d;
      wr_num      <= wr_num_d;
      err         <= err_d;
      guard_cnt_q <= guard_cnt_d;
      guard_num_q <= guard_num_d;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: a 6-thread instance against a
// delayed-commit memory model, plus a 3-thread instance that stresses the guard.
module tb_thread_scheduler;
  localparam int N  = 6;
  localparam int N3 = 3;
  localparam logic [2:0] S_MATCH = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;

  logic CLK = 0, RST = 1, en = 0, out_rdy = 0;
  always #5 CLK = ~CLK;

  logic [2:0] rd_num, rd_state, wr_num, wr_state, out_num;
  logic       wr_en, out_valid, err;
  logic [1:0] rd_num3, wr_num3, out_num3;
  logic [2:0] rd_state3, wr_state3;
  logic       wr_en3, out_valid3, err3;
  logic       one = 1'b1;

  thread_scheduler #(.N_THREADS(N), .THREAD_STATE_MSB(2), .MATCH_STATE(S_MATCH), .NEXT_STATE(S_NEXT)) dut (
    .CLK(CLK), .RST(RST), .en(en), .rd_num(rd_num), .rd_state(rd_state),
    .wr_en(wr_en), .wr_num(wr_num), .wr_state(wr_state),
    .out_valid(out_valid), .out_num(out_num), .out_rdy(out_rdy), .err(err));

  thread_scheduler #(.N_THREADS(N3), .THREAD_STATE_MSB(2), .MATCH_STATE(S_MATCH), .NEXT_STATE(S_NEXT)) dut3 (
    .CLK(CLK), .RST(RST), .en(one), .rd_num(rd_num3), .rd_state(rd_state3),
    .wr_en(wr_en3), .wr_num(wr_num3), .wr_state(wr_state3),
    .out_valid(out_valid3), .out_num(out_num3), .out_rdy(one), .err(err3));

  // ---------------- memory models ----------------
  typedef struct { int num; int due; } pend_t;
  logic [2:0] mem [N];
  logic [2:0] mem_set [N];
  logic [2:0] mem3 [N3];
  logic [2:0] wp3 = '0;
  pend_t      pend[$];
  int         cyc = 0, fixed_d = 0, poke_num = 0;
  logic       load = 0, poke = 0;
  logic [2:0] poke_val = '0;

  assign rd_state  = (int'(rd_num) < N) ? mem[rd_num] : 3'd0;
  assign rd_state3 = (int'(rd_num3) < N3) ? mem3[rd_num3] : 3'd0;

  // A write strobed in cycle W becomes visible in cycle W+d, d in 1..4.
  always @(posedge CLK) begin
    int d;
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= mem_set[i];
      pend.delete();
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due == cyc + 1) begin
          mem[pend[i].num] <= S_NEXT;
          pend.delete(i);
        end
      if (wr_en) begin
        d = (fixed_d != 0) ? fixed_d : int'($urandom_range(1, 4));
        if (d == 1) mem[wr_num] <= S_NEXT;
        else pend.push_back('{int'(wr_num), cyc + d});
      end
      if (poke) mem[poke_num] <= poke_val;
    end
  end

  // Small instance: only thread 0 eligible, commit lands 4 cycles after wr_en.
  always @(posedge CLK) begin
    if (load) begin
      wp3 <= '0;
      mem3[0] <= S_MATCH; mem3[1] <= 3'd0; mem3[2] <= 3'd0;
    end else begin
      wp3 <= {wp3[1:0], wr_en3};
      if (wp3[2]) mem3[wr_num3] <= S_NEXT;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [2:0] exp_q[$];
  int offer_cyc[$];
  logic pv = 0, pv3 = 0, wr_exp = 0, err_m = 0;
  logic [2:0] held = '0, wr_exp_num = '0;
  int offers3 = 0, base3 = 0, wr_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("err", err, err_m);
    chk("d3_err", err3, 0);
    chk("wr_en", wr_en, wr_exp);
    if (wr_en && wr_exp) begin
      chk("wr_num", wr_num, wr_exp_num);
      chk("wr_state", wr_state, S_NEXT);
    end
    if (out_valid && !RST) begin
      if (!pv) begin
        offer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL offer: got thread %0d, expected no offer (t=%0t)", out_num, $time);
        end else chk("offer_num", out_num, exp_q.pop_front());
      end else chk("hold_num", out_num, held);
    end
    if (out_valid3 && !pv3 && !RST) begin
      offers3 <= offers3 + 1;
      chk("d3_num", out_num3, 0);
    end
    held       <= out_num;
    pv         <= out_valid;
    pv3        <= out_valid3;
    wr_exp     <= out_valid && out_rdy && !RST;
    wr_exp_num <= out_num;
    wr_cnt     <= wr_cnt + (wr_en ? 1 : 0);
    err_m      <= !RST && (err_m || (out_valid && mem[out_num] != S_MATCH));
  end

  // ---------------- stimulus ----------------
  function automatic logic [2:0] nonmatch();
    logic [2:0] v = 3'($urandom_range(0, 7));
    if (v == S_MATCH) v = 3'd0;
    return v;
  endfunction

  task automatic set_mem(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) mem_set[i] = mask[i] ? S_MATCH : nonmatch();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset(input bit check3, output int r0);
    if (check3) chk("d3_offers", offers3 - base3, 1);
    RST = 1; load = 1; en = 0; out_rdy = 0;
    exp_q.delete();
    offer_cyc.delete();
    for (int i = 0; i < N; i++) if (mem_set[i] == S_MATCH) exp_q.push_back(3'(i));
    @(posedge CLK); #1 load = 0;
    @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_num", out_num, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_num", wr_num, 0);
    chk("rst_wr_state", wr_state, S_NEXT);
    chk("rst_err", err, 0);
    @(posedge CLK); #1 RST = 0;
    r0 = cyc;
    base3 = offers3;
  endtask

  task automatic wait_offers(input int n, input int budget, input string name);
    int k = 0;
    while (offer_cyc.size() < n && k < budget) begin ticks(1); k++; end
    if (offer_cyc.size() < n) begin
      checks++; errors++;
      $display("FAIL %s: timeout, got %0d offers expected %0d", name, offer_cyc.size(), n);
    end
  endtask

  initial begin
    int r0, wb;
    // single eligible thread: offer 5 cycles after reset release
    set_mem(6'b010000);
    do_reset(0, r0);
    en = 1; out_rdy = 1;
    wait_offers(1, 20, "t1_wait");
    if (offer_cyc.size() > 0) chk("t1_latency", offer_cyc[0] - r0, 5);
    ticks(20);

    // 1,2,5 in order; 2 follows 1 without rescanning from 0
    set_mem(6'b100110);
    do_reset(1, r0);
    en = 1; out_rdy = 1;
    wait_offers(3, 40, "t2_wait");
    if (offer_cyc.size() >= 3) begin
      chk("t2_lat1", offer_cyc[0] - r0, 2);
      chk("t2_lat2", offer_cyc[1] - r0, 5);
      chk("t2_lat5", offer_cyc[2] - r0, 10);
    end
    ticks(20);
    chk("t2_drain", exp_q.size(), 0);

    // long backpressure then a single write
    set_mem(6'b000100);
    do_reset(1, r0);
    en = 1; out_rdy = 0;
    wait_offers(1, 20, "t3_wait");
    wb = wr_cnt;
    ticks(9);
    @(negedge CLK);
    chk("t3_still_valid", out_valid, 1);
    chk("t3_no_wr", wr_cnt - wb, 0);
    @(posedge CLK); #1 out_rdy = 1;
    ticks(12);
    chk("t3_one_wr", wr_cnt - wb, 1);

    // delayed commit must not cause re-selection
    fixed_d = 2;
    set_mem(6'b001000);
    do_reset(1, r0);
    en = 1; out_rdy = 1;
    ticks(40);
    chk("t4_offers", offer_cyc.size(), 1);
    chk("t4_err", err, 0);
    fixed_d = 0;

    // held thread changes state -> sticky err; reset mid-HOLD
    set_mem(6'b001000);
    do_reset(1, r0);
    en = 1; out_rdy = 0;
    wait_offers(1, 20, "t5_wait");
    poke_num = 3; poke_val = 3'd6; poke = 1;
    ticks(1); poke = 0;
    ticks(3);
    @(negedge CLK);
    chk("t5_err_set", err, 1);
    @(posedge CLK); #1;
    poke_val = S_MATCH; poke = 1;
    ticks(1); poke = 0;
    ticks(3);
    @(negedge CLK);
    chk("t5_err_sticky", err, 1);
    @(posedge CLK); #1;
    set_mem(6'b001000);
    do_reset(1, r0);
    en = 1; out_rdy = 1;
    wait_offers(1, 20, "t5_wait2");
    if (offer_cyc.size() > 0) chk("t5_ptr0_latency", offer_cyc[0] - r0, 4);
    ticks(15);

    // randomized epochs: each MATCH thread offered once, in ascending order
    for (int e = 0; e < 8; e++) begin
      for (int i = 0; i < N; i++) mem_set[i] = ($urandom % 2 == 0) ? S_MATCH : nonmatch();
      do_reset(1, r0);
      for (int c = 0; c < 200; c++) begin
        en = ($urandom % 4) != 0;
        out_rdy = ($urandom % 2) != 0;
        ticks(1);
      end
      chk("rand_drain", exp_q.size(), 0);
    end
    chk("d3_offers", offers3 - base3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
